screen_mem_arbiter: RTL and testbench
=====================================

SCREEN_MEM_ARBITER -- requirements
Module: screen_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, screen word address width (8192 x 16-bit words, 512x256 monochrome).
REQ-002 SHALL have parameter DATA_W, default 16, screen word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 3, the number of consecutive denied cycles after which a pending CPU request wins.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-006 SHALL have port cpu_req, input, 1, CPU access request, held high with stable cpu_we/cpu_addr/cpu_wdata until cpu_ack.
REQ-007 SHALL have ports cpu_we, input, 1, write enable; cpu_addr, input, ADDR_W, word address; cpu_wdata, input, DATA_W, write data.
REQ-008 SHALL have port cpu_ack, output, 1, a one-cycle completion pulse.
REQ-009 SHALL have port cpu_rdata, output, DATA_W, read data, valid while cpu_ack is high.
REQ-010 SHALL have ports vid_req, input, 1, a one-cycle scanout fetch pulse, and vid_addr, input, ADDR_W, the fetch address.
REQ-011 SHALL have ports vid_valid, output, 1, fetch-data strobe; vid_rdata, output, DATA_W, fetch data; vid_ovf, output, 1, sticky lost-fetch flag.
REQ-012 SHALL have ports mem_en, output, 1; mem_we, output, 1; mem_addr, output, ADDR_W; mem_wdata, output, DATA_W; mem_rdata, input, DATA_W. These drive a single-port synchronous RAM with 1-cycle read latency.

Function
REQ-013 SHALL capture a vid_req pulse and its vid_addr into a one-entry video pending register (vid_pend).
REQ-014 SHALL set vid_ovf and overwrite the stored address with the new one when vid_req arrives while vid_pend is set and is not granted that cycle.
REQ-015 SHALL treat the CPU as pending when cpu_req=1 and cpu_busy=0; cpu_busy is set from grant until its cpu_ack cycle, inclusive.
REQ-016 SHALL issue at most one memory access per cycle, arbitrated combinationally each cycle:
- starve_cnt >= STARVE_LIMIT and CPU pending -> CPU.
- else vid_pend, or a vid_req arriving this cycle -> video.
- else CPU pending -> CPU.
- else idle (mem_en=0).
REQ-017 SHALL, on a video grant, drive mem_en=1, mem_we=0, mem_addr=the pending video address (or vid_addr when it arrives the same cycle), and clear vid_pend.
REQ-018 SHALL, on a CPU grant, drive mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata, and set cpu_busy.
REQ-019 SHALL record the grant owner in a state register with states IDLE, VID and CPU, updated every cycle to the owner of the access issued that cycle; back-to-back grants are allowed.
REQ-020 SHALL, in the cycle after a VID access, pulse vid_valid=1 with vid_rdata=mem_rdata; latency from vid_req with no contention is 1 cycle.
REQ-021 SHALL, in the cycle after a CPU access, pulse cpu_ack=1 with cpu_rdata=mem_rdata for reads; for writes, cpu_ack pulses at the same latency and cpu_rdata is don't-care.
REQ-022 SHALL clear cpu_busy in the cycle after cpu_ack; cpu_req still high then is a new request.
REQ-023 SHALL increment starve_cnt, saturating at STARVE_LIMIT, each cycle the CPU is pending and not granted, and clear it on a CPU grant or when the CPU is not pending.
REQ-024 SHALL hold mem_wdata and mem_we at 0 when mem_en=0.
REQ-025 SHALL keep vid_ovf set until rst.

Reset
REQ-026 SHALL, on rst, set every output to 0 (cpu_ack, cpu_rdata, vid_valid, vid_rdata, vid_ovf, mem_en, mem_we, mem_addr, mem_wdata).
REQ-027 SHALL, on rst, clear vid_pend, cpu_busy and starve_cnt, set the state to IDLE, and drop any in-flight access without an ack or valid.
REQ-028 SHALL ignore cpu_req and vid_req in a cycle with rst=1.

Structure
REQ-029 SHALL take ADDR_W and DATA_W defaults and the state enum {IDLE, VID, CPU} from the shared package screen_pkg.
REQ-030 SHALL be one flat module with no sub-module; the RAM is external.

Verification
REQ-031 SHALL cover: vid_req with addr 0x0010 in an otherwise idle cycle -> mem_en=1, mem_addr=0x0010 the same cycle; next cycle vid_valid=1 with vid_rdata=RAM[0x0010].
REQ-032 SHALL cover: CPU write addr 0x1FFF data 0xA5A5 -> cpu_ack 1 cycle after grant; a following CPU read of 0x1FFF -> cpu_rdata=0xA5A5.
REQ-033 SHALL cover: cpu_req and vid_req in the same cycle with starve_cnt=0 -> video granted first, CPU granted next cycle, cpu_ack 2 cycles after the request.
REQ-034 SHALL cover: vid_req every cycle with CPU pending -> CPU granted on the 4th cycle (starve_cnt=3); vid_ovf=0 only if the deferred fetch is served the next cycle without a new pulse, else vid_ovf=1.
REQ-035 SHALL cover: two vid_req pulses while the CPU holds the grant -> vid_ovf=1, and only the second address is fetched.
REQ-036 SHALL cover: rst asserted the cycle after a CPU grant -> no cpu_ack, all outputs 0 the next cycle, state IDLE.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared definitions for the screen memory path: default geometry and arbiter owner states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package screen_pkg;

  // 512x256 monochrome frame = 8192 words of 16 bits
  localparam int SCREEN_ADDR_W       = 13;
  localparam int SCREEN_DATA_W       = 16;
  localparam int SCREEN_STARVE_LIMIT = 3;

  // Owner of the memory access issued in a cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VID  = 2'd1,
    CPU  = 2'd2
  } owner_t;

endpackage

// File: rtl/screen_mem_arbiter.sv
// Shares one single-port screen RAM between a held CPU request and one-cycle video fetch pulses.
// Latency: access issued combinationally in the grant cycle; cpu_ack / vid_valid one cycle later.
// Backpressure: CPU waits (req held) behind video up to STARVE_LIMIT cycles; video has a 1-deep pending slot, overrun sets sticky vid_ovf.
module screen_mem_arbiter
  import screen_pkg::*;
#(
  parameter int ADDR_W       = SCREEN_ADDR_W,
  parameter int DATA_W       = SCREEN_DATA_W,
  parameter int STARVE_LIMIT = SCREEN_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_ovf,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  owner_t              state_q, state_d;
  logic                vid_pend_q, vid_pend_d;
  logic [ADDR_W-1:0]   vid_pend_addr_q, vid_pend_addr_d;
  logic                cpu_busy_q, cpu_busy_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                vid_ovf_q, vid_ovf_d;
  logic                cpu_pend;
  logic                vid_want;

  // Owner register: remembers who used the RAM this cycle so the read data can be routed next cycle
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Arbitration, RAM drive, response routing and next values of the bookkeeping registers
  always_comb begin
    state_d         = IDLE;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    vid_pend_d      = vid_pend_q;
    vid_pend_addr_d = vid_pend_addr_q;
    cpu_busy_d      = cpu_busy_q;
    starve_d        = starve_q;
    vid_ovf_d       = vid_ovf_q;

    // Responses for last cycle's access; a reset cycle drops them
    cpu_ack   = (state_q == CPU) && !rst;
    cpu_rdata = cpu_ack ? mem_rdata : '0;
    vid_valid = (state_q == VID) && !rst;
    vid_rdata = vid_valid ? mem_rdata : '0;

    if (cpu_ack) cpu_busy_d = 1'b0;

    cpu_pend = cpu_req && !cpu_busy_q && !rst;
    vid_want = (vid_pend_q || vid_req) && !rst;

    if (cpu_pend && (starve_q >= LIMIT)) state_d = CPU;
    else if (vid_want)                   state_d = VID;
    else if (cpu_pend)                   state_d = CPU;

    case (state_d)
      VID: begin
        mem_en     = 1'b1;
        // A fresh pulse supersedes the older pending fetch: the newest scanout address is the useful one
        mem_addr   = vid_req ? vid_addr : vid_pend_addr_q;
        vid_pend_d = 1'b0;
      end
      CPU: begin
        mem_en     = 1'b1;
        mem_we     = cpu_we;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        cpu_busy_d = 1'b1;
      end
      default: ;
    endcase

    // Park a fetch that could not be served this cycle
    if (vid_req && !rst && (state_d != VID)) begin
      vid_pend_d      = 1'b1;
      vid_pend_addr_d = vid_addr;
    end

    // Any new pulse landing on an unserved pending fetch loses one of them
    if (vid_req && vid_pend_q && !rst) vid_ovf_d = 1'b1;

    if (cpu_pend && (state_d != CPU))
      starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 1'b1;
    else
      starve_d = '0;
  end

  // Bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vid_pend_q      <= 1'b0;
      vid_pend_addr_q <= '0;
      cpu_busy_q      <= 1'b0;
      starve_q        <= '0;
      vid_ovf_q       <= 1'b0;
    end else begin
      vid_pend_q      <= vid_pend_d;
      vid_pend_addr_q <= vid_pend_addr_d;
      cpu_busy_q      <= cpu_busy_d;
      starve_q        <= starve_d;
      vid_ovf_q       <= vid_ovf_d;
    end
  end

  assign vid_ovf = vid_ovf_q;

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Randomized and directed bench for screen_mem_arbiter against a cycle-level behavioural model.
// Latency: n/a (testbench).
// Backpressure: CPU driver holds its request until the modelled ack.
module tb_screen_mem_arbiter;
  import screen_pkg::*;

  localparam int AW  = 13;
  localparam int DW  = 16;
  localparam int LIM = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_valid;
  logic [DW-1:0] vid_rdata;
  logic          vid_ovf;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  screen_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_valid(vid_valid), .vid_rdata(vid_rdata), .vid_ovf(vid_ovf),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // External RAM driven by the DUT, and the model's own copy
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] ref_ram [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model state: pending video fetch, CPU wait count, sticky overflow, and what completes this cycle
  bit            m_vpend;
  logic [AW-1:0] m_vaddr;
  int            m_starve;
  bit            m_ovf;
  int            m_resp;      // 0 nothing, 1 video, 2 cpu
  bit            m_resp_rd;
  logic [DW-1:0] m_resp_dat;
  bit            e_ack;

  // One clock cycle: drive inputs, check against the model, advance the model on the edge
  task automatic step(input bit r, input bit creq, input bit cwe, input logic [AW-1:0] caddr,
                      input logic [DW-1:0] cwd, input bit vreq, input logic [AW-1:0] vaddr);
    int            grant;
    bit            cpend;
    logic [AW-1:0] gaddr;
    @(negedge clk);
    rst = r; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    vid_req = vreq; vid_addr = vaddr;
    #1;
    e_ack = !r && (m_resp == 2);
    cpend = !r && creq && !e_ack;
    grant = 0;
    if (!r) begin
      if (cpend && m_starve >= LIM)  grant = 2;
      else if (m_vpend || vreq)      grant = 1;
      else if (cpend)                grant = 2;
    end
    gaddr = (grant == 2) ? caddr : (vreq ? vaddr : m_vaddr);

    chk("cpu_ack", 32'(cpu_ack), 32'(e_ack));
    if (e_ack && m_resp_rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_resp_dat));
    chk("vid_valid", 32'(vid_valid), 32'(!r && m_resp == 1));
    if (!r && m_resp == 1) chk("vid_rdata", 32'(vid_rdata), 32'(m_resp_dat));
    chk("vid_ovf", 32'(vid_ovf), 32'(m_ovf));
    chk("mem_en", 32'(mem_en), 32'(grant != 0));
    chk("mem_we", 32'(mem_we), 32'(grant == 2 && cwe));
    if (grant != 0) chk("mem_addr", 32'(mem_addr), 32'(gaddr));
    if (grant == 0) chk("mem_wdata_idle", 32'(mem_wdata), 32'd0);
    if (grant == 2) chk("mem_wdata", 32'(mem_wdata), 32'(cwd));
    if (r) begin
      chk("rst_mem_addr",  32'(mem_addr),  32'd0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      chk("rst_vid_rdata", 32'(vid_rdata), 32'd0);
    end

    @(posedge clk);
    if (r) begin
      m_vpend = 0; m_starve = 0; m_ovf = 0; m_resp = 0;
    end else begin
      if (vreq && m_vpend) m_ovf = 1;
      if (grant == 1) m_vpend = 0;
      else if (vreq) begin m_vpend = 1; m_vaddr = vaddr; end
      m_starve = (cpend && grant != 2) ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
      m_resp = grant;
      if (grant != 0) begin
        m_resp_dat = ref_ram[gaddr];
        m_resp_rd  = !(grant == 2 && cwe);
        if (grant == 2 && cwe) ref_ram[gaddr] = cwd;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0, 0, '0);
  endtask

  bit            c_active, c_we, r, v;
  logic [AW-1:0] c_addr, va;
  logic [DW-1:0] c_wd;

  initial begin
    rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; vid_req = 0; vid_addr = '0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'($urandom);
    ram[16] = 16'h1234;
    for (int i = 0; i < 5; i++) ram[32 + i] = 16'hB000 + DW'(i);
    for (int i = 0; i < (1 << AW); i++) ref_ram[i] = ram[i];
    m_vpend = 0; m_vaddr = '0; m_starve = 0; m_ovf = 0; m_resp = 0; m_resp_rd = 0; m_resp_dat = '0;
    repeat (2) @(posedge clk);
    step(1, 0, 0, '0, '0, 0, '0);

    // Idle video fetch: same-cycle access, data next cycle
    step(0, 0, 0, '0, '0, 1, 13'h0010);
    chk("t_vid_valid", 32'(vid_valid), 32'd1);
    chk("t_vid_rdata", 32'(vid_rdata), 32'h1234);
    idle();

    // CPU write then read back of the top address
    step(0, 1, 1, 13'h1FFF, 16'hA5A5, 0, '0);
    chk("t_wr_ack", 32'(cpu_ack), 32'd1);
    step(0, 1, 1, 13'h1FFF, 16'hA5A5, 0, '0);
    step(0, 1, 0, 13'h1FFF, '0, 0, '0);
    chk("t_rd_ack", 32'(cpu_ack), 32'd1);
    chk("t_rd_data", 32'(cpu_rdata), 32'hA5A5);
    step(0, 1, 0, 13'h1FFF, '0, 0, '0);
    idle();

    // Simultaneous requests: video first, CPU acked two cycles after request
    step(0, 1, 0, 13'd5, '0, 1, 13'd6);
    chk("t_both_vid", 32'(vid_valid), 32'd1);
    chk("t_both_noack", 32'(cpu_ack), 32'd0);
    step(0, 1, 0, 13'd5, '0, 0, '0);
    chk("t_both_ack", 32'(cpu_ack), 32'd1);
    step(0, 1, 0, 13'd5, '0, 0, '0);
    idle();

    // Starvation limit, deferred fetch served without a new pulse
    for (int i = 0; i < 4; i++) step(0, 1, 0, 13'd7, '0, 1, 13'h20 + AW'(i));
    chk("t_starve_ack", 32'(cpu_ack), 32'd1);
    step(0, 1, 0, 13'd7, '0, 0, '0);
    chk("t_defer_valid", 32'(vid_valid), 32'd1);
    chk("t_defer_rdata", 32'(vid_rdata), 32'hB003);
    chk("t_defer_noovf", 32'(vid_ovf), 32'd0);
    idle();
    step(1, 0, 0, '0, '0, 0, '0);

    // Starvation limit, then a second pulse lands on the deferred one
    for (int i = 0; i < 4; i++) step(0, 1, 0, 13'd7, '0, 1, 13'h20 + AW'(i));
    step(0, 1, 0, 13'd7, '0, 1, 13'h24);
    chk("t_ovf_rdata", 32'(vid_rdata), 32'hB004);
    chk("t_ovf_set", 32'(vid_ovf), 32'd1);
    idle();
    idle();
    chk("t_ovf_sticky", 32'(vid_ovf), 32'd1);

    // Reset right after a CPU grant drops the ack
    step(1, 0, 0, '0, '0, 0, '0);
    step(0, 1, 1, 13'd9, 16'h5555, 0, '0);
    step(1, 1, 1, 13'd9, 16'h5555, 0, '0);
    chk("t_rst_noack", 32'(cpu_ack), 32'd0);
    chk("t_rst_state", 32'(dut.state_q), 32'(IDLE));
    idle();

    // Randomized traffic with varying video density and rare resets
    c_active = 0; c_we = 0; c_addr = '0; c_wd = '0;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 199) == 0);
      if (!c_active && $urandom_range(0, 2) == 0) begin
        c_active = 1;
        c_we     = 1'($urandom_range(0, 1));
        c_addr   = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
        c_wd     = DW'($urandom);
      end
      v  = ($urandom_range(0, 3) <= (k / 500) % 4);
      va = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      step(r, c_active, c_we, c_addr, c_wd, v, va);
      if (r || e_ack) c_active = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
